polygon_frame_loader: RTL and testbench

Once per frame, this block walks a polygon table in BRAM, subtracts the camera position from every vertex, and fills shadow registers. It then commits them atomically to the active vertex/count arrays that feed the per-polygon draw_polygon/in_polygon instances. It is the configuration sequencer for the polygon rasteriser. It guarantees the rasteriser never sees a half-updated polygon set mid-frame.

---
 rtl/polygon_pkg.sv | 33 +++
 rtl/polygon_read_tag_pipe.sv | 33 +++
 rtl/polygon_frame_loader.sv | 182 ++++++++++++++++++
 tb/tb_polygon_frame_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/polygon_pkg.sv
// Shared types, table field offsets and helpers for the polygon rasteriser
// configuration path (frame loader and draw_polygon instances).
package polygon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } loader_state_e;

  // Table word layout: word 0 of each polygon is the header, words 1..M are vertices.
  localparam int HEADER_COUNT_LSB = 0;
  localparam int VERTEX_X_MSB     = 63;
  localparam int VERTEX_X_LSB     = 32;
  localparam int VERTEX_Y_MSB     = 31;
  localparam int VERTEX_Y_LSB     = 0;
  localparam int TABLE_WORD_WIDTH = 64;
  localparam int COORD_WIDTH      = 32;

  // Colour encoding shared with draw_polygon.
  localparam int                   COLOR_WIDTH = 12;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BACKGROUND = 12'h000;
  localparam logic [COLOR_WIDTH-1:0] COLOR_FILL       = 12'hFFF;
  localparam logic [COLOR_WIDTH-1:0] COLOR_EDGE       = 12'hF00;

  // A polygon is drawable only with at least a triangle and no more vertices than slots.
  function automatic logic count_is_valid(input int unsigned count,
                                          input int unsigned max_vertices);
    return (count >= 3) && (count <= max_vertices);
  endfunction

endpackage

// File: rtl/polygon_read_tag_pipe.sv
// Delays the {valid, poly index, word index} tag of each table read so it
// lines up with the BRAM response READ_LATENCY cycles later.
module polygon_read_tag_pipe #(
  parameter int DEPTH  = 2,
  parameter int POLY_W = 3,
  parameter int WORD_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              in_valid,
  input  logic [POLY_W-1:0] in_poly,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  output logic [POLY_W-1:0] out_poly,
  output logic [WORD_W-1:0] out_word
);

  localparam int TAG_W = 1 + POLY_W + WORD_W;

  logic [TAG_W-1:0] stages [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= {in_valid, in_poly, in_word};
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign {out_valid, out_poly, out_word} = stages[DEPTH-1];

endmodule

// File: rtl/polygon_frame_loader.sv
// Per-frame polygon table walker: reads the table, makes vertices camera-relative
// in shadow registers, then commits them to the active arrays in a single edge.
module polygon_frame_loader
  import polygon_pkg::*;
#(
  parameter int NUM_POLYGONS     = 8,
  parameter int MAX_NUM_VERTICES = 4,
  parameter int READ_LATENCY     = 2,
  parameter int ADDR_WIDTH       = $clog2(NUM_POLYGONS*(MAX_NUM_VERTICES+1))
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start_in,
  input  logic [31:0]                     camera_x_in,
  input  logic [31:0]                     camera_y_in,
  output logic                            rd_en_out,
  output logic [ADDR_WIDTH-1:0]           rd_addr_out,
  input  logic [63:0]                     rd_data_in,
  output logic signed [31:0]              xs_out [NUM_POLYGONS][MAX_NUM_VERTICES],
  output logic signed [31:0]              ys_out [NUM_POLYGONS][MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES):0] num_points_out [NUM_POLYGONS],
  output logic [NUM_POLYGONS-1:0]         poly_valid_out,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [7:0]                      overrun_count_out
);

  localparam int STRIDE    = MAX_NUM_VERTICES + 1;
  localparam int LAST_ADDR = NUM_POLYGONS * STRIDE - 1;
  localparam int POLY_W    = (NUM_POLYGONS > 1) ? $clog2(NUM_POLYGONS) : 1;
  localparam int WORD_W    = $clog2(STRIDE);
  localparam int VERT_W    = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
  localparam int COUNT_W   = $clog2(MAX_NUM_VERTICES) + 1;
  localparam int DRAIN_W   = $clog2(READ_LATENCY + 1);

  loader_state_e      state;
  logic signed [31:0] cam_x;
  logic signed [31:0] cam_y;
  logic [POLY_W-1:0]  issue_poly;
  logic [WORD_W-1:0]  issue_word;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               tag_valid;
  logic [POLY_W-1:0]  tag_poly;
  logic [WORD_W-1:0]  tag_word;
  logic [VERT_W-1:0]  tag_vert;

  logic signed [31:0] shadow_x   [NUM_POLYGONS][MAX_NUM_VERTICES];
  logic signed [31:0] shadow_y   [NUM_POLYGONS][MAX_NUM_VERTICES];
  logic [COUNT_W-1:0] shadow_num [NUM_POLYGONS];

  logic start_accept;
  logic overrun_event;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    start_accept  = 1'b0;
    overrun_event = 1'b0;
    if (frame_start_in) begin
      if (state == IDLE) start_accept  = 1'b1;
      else               overrun_event = 1'b1;
    end
  end

  assign rd_en_out      = (state == LOAD);
  assign busy_out       = (state != IDLE);
  assign frame_done_out = (state == COMMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      cam_x             <= '0;
      cam_y             <= '0;
      rd_addr_out       <= '0;
      issue_poly        <= '0;
      issue_word        <= '0;
      drain_cnt         <= '0;
      overrun_count_out <= '0;
    end else begin
      if (overrun_event && overrun_count_out != 8'hFF)
        overrun_count_out <= overrun_count_out + 8'd1;

      unique case (state)
        IDLE: begin
          if (start_accept) begin
            state       <= LOAD;
            cam_x       <= camera_x_in;
            cam_y       <= camera_y_in;
            rd_addr_out <= '0;
            issue_poly  <= '0;
            issue_word  <= '0;
          end
        end
        LOAD: begin
          if (rd_addr_out == ADDR_WIDTH'(LAST_ADDR)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            rd_addr_out <= rd_addr_out + 1'b1;
            if (issue_word == WORD_W'(STRIDE - 1)) begin
              issue_word <= '0;
              issue_poly <= issue_poly + 1'b1;
            end else begin
              issue_word <= issue_word + 1'b1;
            end
          end
        end
        // The last response lands READ_LATENCY cycles after the final read.
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(READ_LATENCY - 1)) state <= COMMIT;
          else                                         drain_cnt <= drain_cnt + 1'b1;
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  polygon_read_tag_pipe #(
    .DEPTH  (READ_LATENCY),
    .POLY_W (POLY_W),
    .WORD_W (WORD_W)
  ) u_tag_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (rd_en_out),
    .in_poly   (issue_poly),
    .in_word   (issue_word),
    .out_valid (tag_valid),
    .out_poly  (tag_poly),
    .out_word  (tag_word)
  );

  assign tag_vert = VERT_W'(tag_word - WORD_W'(1));

  // NOTE: these arrays are flop banks, not RAM, so resetting them is legal and required.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int p = 0; p < NUM_POLYGONS; p++) begin
        shadow_num[p] <= '0;
        for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
          shadow_x[p][v] <= '0;
          shadow_y[p][v] <= '0;
        end
      end
    end else if (tag_valid) begin
      if (tag_word == '0) begin
        shadow_num[tag_poly] <= rd_data_in[HEADER_COUNT_LSB +: COUNT_W];
      end else begin
        shadow_x[tag_poly][tag_vert] <=
          $signed(rd_data_in[VERTEX_X_MSB:VERTEX_X_LSB]) - cam_x;
        shadow_y[tag_poly][tag_vert] <=
          $signed(rd_data_in[VERTEX_Y_MSB:VERTEX_Y_LSB]) - cam_y;
      end
    end
  end

  // Active arrays change only on the COMMIT edge, so the rasteriser sees whole frames.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      poly_valid_out <= '0;
      for (int p = 0; p < NUM_POLYGONS; p++) begin
        num_points_out[p] <= '0;
        for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
          xs_out[p][v] <= '0;
          ys_out[p][v] <= '0;
        end
      end
    end else if (state == COMMIT) begin
      for (int p = 0; p < NUM_POLYGONS; p++) begin
        num_points_out[p] <= shadow_num[p];
        poly_valid_out[p] <= count_is_valid(32'(shadow_num[p]), MAX_NUM_VERTICES);
        for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
          xs_out[p][v] <= shadow_x[p][v];
          ys_out[p][v] <= shadow_y[p][v];
        end
      end
    end
  end

endmodule

// File: tb/tb_polygon_frame_loader.sv
// Directed bench for polygon_frame_loader: cycle-exact frame timing, vertex
// arithmetic, validity flags, overrun counting and mid-load reset.
module tb_polygon_frame_loader;

  localparam int N     = 8;
  localparam int M     = 4;
  localparam int L     = 2;
  localparam int S     = M + 1;
  localparam int WORDS = N * S;
  localparam int AW    = $clog2(WORDS);

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   frame_start_in;
  logic [31:0]            camera_x_in;
  logic [31:0]            camera_y_in;
  logic                   rd_en_out;
  logic [AW-1:0]          rd_addr_out;
  logic [63:0]            rd_data_in;
  logic signed [31:0]     xs_out [N][M];
  logic signed [31:0]     ys_out [N][M];
  logic [$clog2(M):0]     num_points_out [N];
  logic [N-1:0]           poly_valid_out;
  logic                   busy_out;
  logic                   frame_done_out;
  logic [7:0]             overrun_count_out;

  logic [63:0] table_mem [WORDS];
  logic [63:0] bram_d1;

  int checks   = 0;
  int failures = 0;

  polygon_frame_loader #(
    .NUM_POLYGONS     (N),
    .MAX_NUM_VERTICES (M),
    .READ_LATENCY     (L)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .frame_start_in    (frame_start_in),
    .camera_x_in       (camera_x_in),
    .camera_y_in       (camera_y_in),
    .rd_en_out         (rd_en_out),
    .rd_addr_out       (rd_addr_out),
    .rd_data_in        (rd_data_in),
    .xs_out            (xs_out),
    .ys_out            (ys_out),
    .num_points_out    (num_points_out),
    .poly_valid_out    (poly_valid_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .overrun_count_out (overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle BRAM model; garbage on the bus whenever no read was issued.
  always @(posedge clk_in) begin
    bram_d1    <= rd_en_out ? table_mem[rd_addr_out] : 64'hDEAD_BEEF_DEAD_BEEF;
    rd_data_in <= bram_d1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] cx, input logic [31:0] cy);
    bit seen;
    seen = 1'b0;
    camera_x_in    = cx;
    camera_y_in    = cy;
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (frame_done_out) seen = 1'b1;
      else                step();
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    step();
  endtask

  task automatic fill_table();
    for (int i = 0; i < WORDS; i++) table_mem[i] = 64'd0;
    // Polygon 0: count 3 in low bits, upper header bits are junk.
    table_mem[0]  = 64'hABCD_0000_0000_000B;
    table_mem[1]  = {32'd100, 32'd50};
    table_mem[2]  = {32'd200, 32'd50};
    table_mem[3]  = {32'd150, 32'd120};
    table_mem[5]  = 64'd2;
    table_mem[6]  = {32'd7, 32'd8};
    table_mem[10] = 64'd5;
    table_mem[15] = 64'd4;
    table_mem[16] = {32'd1000, 32'd20};
    table_mem[20] = 64'd0;
    table_mem[21] = {32'h0000_0005, 32'd0};
    table_mem[22] = {32'h8000_0000, 32'd0};
  endtask

  initial begin
    int done_cnt;
    bit idle_seen;

    rst_in         = 1'b1;
    frame_start_in = 1'b0;
    camera_x_in    = '0;
    camera_y_in    = '0;
    fill_table();
    step();
    step();

    check("rst_busy",       32'(busy_out),          32'd0);
    check("rst_rd_en",      32'(rd_en_out),         32'd0);
    check("rst_rd_addr",    32'(rd_addr_out),       32'd0);
    check("rst_frame_done", 32'(frame_done_out),    32'd0);
    check("rst_overrun",    32'(overrun_count_out), 32'd0);
    check("rst_poly_valid", 32'(poly_valid_out),    32'd0);
    check("rst_xs_0_0",     xs_out[0][0],           32'd0);
    check("rst_num_pts_3",  32'(num_points_out[3]), 32'd0);
    rst_in = 1'b0;
    step();

    // Frame A walked cycle by cycle; cycle 0 is the start pulse.
    camera_x_in    = 32'd40;
    camera_y_in    = 32'd10;
    frame_start_in = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      frame_start_in = (k == 10 || k == 43);
      if (k == 5) begin
        camera_x_in = 32'd999;
        camera_y_in = 32'd999;
      end
      check($sformatf("rd_en_c%0d", k), 32'(rd_en_out), 32'(k <= 40));
      if (k <= 40) check($sformatf("rd_addr_c%0d", k), 32'(rd_addr_out), 32'(k - 1));
      check($sformatf("busy_c%0d", k), 32'(busy_out), 32'(k <= 43));
      check($sformatf("frame_done_c%0d", k), 32'(frame_done_out), 32'(k == 43));
      if (k == 43) check("active_held_before_commit", xs_out[0][0], 32'd0);
      if (k == 44) begin
        check("active_new_at_c44", xs_out[0][0], 32'd60);
        check("overrun_two", 32'(overrun_count_out), 32'd2);
      end
    end
    frame_start_in = 1'b0;

    check("xs_0_0",  xs_out[0][0], 32'd60);
    check("xs_0_1",  xs_out[0][1], 32'd160);
    check("xs_0_2",  xs_out[0][2], 32'd110);
    check("xs_0_3",  xs_out[0][3], 32'hFFFF_FFD8);
    check("ys_0_0",  ys_out[0][0], 32'd40);
    check("ys_0_1",  ys_out[0][1], 32'd40);
    check("ys_0_2",  ys_out[0][2], 32'd110);
    check("ys_0_3",  ys_out[0][3], 32'hFFFF_FFF6);
    check("xs_1_0_invalid_committed", xs_out[1][0], 32'hFFFF_FFDF);
    check("ys_1_0_invalid_committed", ys_out[1][0], 32'hFFFF_FFFE);
    check("xs_3_0",  xs_out[3][0], 32'd960);
    check("xs_4_0",  xs_out[4][0], 32'hFFFF_FFDD);
    check("xs_4_1",  xs_out[4][1], 32'h7FFF_FFD8);
    check("num_pts_0", 32'(num_points_out[0]), 32'd3);
    check("num_pts_1", 32'(num_points_out[1]), 32'd2);
    check("num_pts_2", 32'(num_points_out[2]), 32'd5);
    check("num_pts_3", 32'(num_points_out[3]), 32'd4);
    check("poly_valid_frame_a", 32'(poly_valid_out), 32'h0000_0009);

    run_frame(32'd10, 32'd0);
    check("xs_4_0_negative", xs_out[4][0], 32'hFFFF_FFFB);
    run_frame(32'd1, 32'd0);
    check("xs_4_1_wrap", xs_out[4][1], 32'h7FFF_FFFF);
    check("overrun_unchanged", 32'(overrun_count_out), 32'd2);

    // Holding the start request high overruns ~43 times per frame.
    frame_start_in = 1'b1;
    repeat (400) step();
    frame_start_in = 1'b0;
    check("overrun_saturated", 32'(overrun_count_out), 32'd255);
    idle_seen = 1'b0;
    for (int i = 0; i < 100 && !idle_seen; i++) begin
      if (!busy_out) idle_seen = 1'b1;
      else           step();
    end
    check("idle_after_saturation", 32'(idle_seen), 32'd1);
    step();

    // Reset during LOAD: start at cycle 0, reset sampled at end of cycle 20.
    frame_start_in = 1'b1;
    camera_x_in    = 32'd40;
    camera_y_in    = 32'd10;
    for (int k = 1; k <= 20; k++) begin
      step();
      frame_start_in = 1'b0;
    end
    rst_in = 1'b1;
    step();
    check("mid_rst_busy",       32'(busy_out),          32'd0);
    check("mid_rst_rd_en",      32'(rd_en_out),         32'd0);
    check("mid_rst_rd_addr",    32'(rd_addr_out),       32'd0);
    check("mid_rst_frame_done", 32'(frame_done_out),    32'd0);
    check("mid_rst_overrun",    32'(overrun_count_out), 32'd0);
    check("mid_rst_poly_valid", 32'(poly_valid_out),    32'd0);
    check("mid_rst_xs_0_0",     xs_out[0][0],           32'd0);
    check("mid_rst_ys_0_0",     ys_out[0][0],           32'd0);
    check("mid_rst_num_pts_0",  32'(num_points_out[0]), 32'd0);
    rst_in   = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_done_out) done_cnt++;
    end
    check("no_done_after_reset", 32'(done_cnt), 32'd0);

    run_frame(32'd40, 32'd10);
    check("reload_xs_0_1",     xs_out[0][1],           32'd160);
    check("reload_ys_0_2",     ys_out[0][2],           32'd110);
    check("reload_poly_valid", 32'(poly_valid_out),    32'h0000_0009);
    check("reload_num_pts_3",  32'(num_points_out[3]), 32'd4);
    check("reload_overrun",    32'(overrun_count_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
